event_pulse_feeder: RTL and testbench
=====================================

EVENT_PULSE_FEEDER -- requirements
Module: event_pulse_feeder

Interface
REQ-001 Parameter CNT_W, default 8: pending-event counter width.
REQ-002 Parameter GAP, default 0: minimum idle cycles between successive sigout pulses.
REQ-003 Port clkin  input  1: single clock; all logic on posedge clkin.
REQ-004 Port clr_in  input  1: reset, synchronous, active-high.
REQ-005 Port ev_valid  input  1: event batch strobe, one cycle per batch.
REQ-006 Port ev_num  input  4: events in batch (0..15), sampled when ev_valid=1.
REQ-007 Port flush  input  1: discard all pending events.
REQ-008 Port full  input  1: back-pressure from the downstream crossing write side; no pulse may be issued while high.
REQ-009 Port sigout  output  1: registered one-cycle event pulse to the crossing sigin.
REQ-010 Port pending  output  CNT_W: events accepted but not yet pulsed.
REQ-011 Port ovf  output  1: sticky, set when an add saturates pending.
REQ-012 Port busy  output  1: high when pending!=0 or state!=IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SEND, GAPW, STALL.
REQ-014 IDLE->SEND when pending!=0 at the start of the cycle.
REQ-015 In SEND with full=0, the next edge SHALL set sigout=1, decrement pending, and go to GAPW if GAP>0, otherwise stay in SEND.
REQ-016 In SEND with full=1, the next edge SHALL set sigout=0 and go to STALL.
REQ-017 STALL->SEND on the first cycle full=0, with no pulse issued in that cycle.
REQ-018 GAPW SHALL count GAP cycles with sigout=0, then go to SEND if pending!=0, otherwise IDLE.
REQ-019 SEND->IDLE when pending reaches 0.
REQ-020 sigout SHALL never be high in two consecutive cycles when GAP>0.
REQ-021 With GAP=0, sigout SHALL be high every cycle while pending!=0 and full=0.
REQ-022 On the same edge, a pulse and an add SHALL apply both: pending_next = pending + ev_num - 1.
REQ-023 Arithmetic SHALL use CNT_W+1 bits and saturate at 2^CNT_W-1.
REQ-024 Any saturation SHALL set ovf; ovf clears only on clr_in.
REQ-025 An ev_valid with ev_num=0 SHALL have no effect.
REQ-026 flush SHALL take priority over all other inputs: the next edge gives pending=0, state IDLE, sigout=0, and any same-cycle ev_valid is discarded.
REQ-027 full sampled high SHALL always suppress the pulse on the next edge, even in a cycle where pending just became non-zero.
REQ-028 Each accepted non-saturated event SHALL produce exactly one sigout pulse; none is lost or duplicated.

Reset
REQ-029 On clr_in=1 at a clock edge: state=IDLE, sigout=0, pending=0, ovf=0, busy=0, gap counter=0.
REQ-030 clr_in SHALL override flush, ev_valid and full.
REQ-031 Asserting clr_in mid-burst SHALL abort it with no further pulses.
REQ-032 Outputs SHALL be valid from the first edge after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2-bit) and the default constants CNT_W=8, GAP=0, EV_NUM_W=4.
REQ-034 The saturating add/decrement SHALL be one sub-module, sat_counter, parameterised by width.
REQ-035 sigout SHALL be driven straight from a flop so it can feed the crossing write counter directly.

Verification
REQ-036 Batch ev_num=5, full=0, GAP=0 -> exactly 5 consecutive sigout pulses starting 2 edges after ev_valid; pending 5->0; busy drops one cycle later.
REQ-037 Batch ev_num=3, GAP=2 -> pulses at cycles t, t+3, t+6; no other sigout highs.
REQ-038 pending=4, full high for 10 cycles after the first pulse -> no pulses during full; the 3 remaining pulses resume one cycle after full falls; total 4.
REQ-039 pending=250 plus ev_num=15 -> pending=255, ovf=1; ovf stays set after the drain; exactly 255 pulses.
REQ-040 Mid-burst flush together with ev_valid ev_num=7 -> next edge pending=0, sigout=0, IDLE; no further pulses.
REQ-041 Back-to-back through clk_domain_cross with a 3:1 clock ratio -> reading-side sigout pulse count equals accepted events; full never violated.

Source files
------------

// File: rtl/event_pulse_feeder_pkg.sv
// Shared definitions for the event pulse feeder: FSM state encoding and default sizes.
package event_pulse_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAPW  = 2'd2,
    STALL = 2'd3
  } feederState_t;

  localparam int DEFAULT_CNT_W = 8;
  localparam int DEFAULT_GAP   = 0;
  localparam int EV_NUM_W      = 4;

endpackage

// File: rtl/event_pulse_feeder_sat_counter.sv
// Saturating add-and-decrement for the pending-event count.
// Works one bit wider than the count so a carry out means the result clipped at all-ones.
module sat_counter
  import event_pulse_feeder_pkg::*;
#(
  parameter int W  = DEFAULT_CNT_W,
  parameter int AW = EV_NUM_W
) (
  input  logic [W-1:0]  i_cur,
  input  logic [AW-1:0] i_add,
  input  logic          i_dec,
  output logic [W-1:0]  o_next,
  output logic          o_sat
);

  localparam int WX = W + 1;

  logic [W:0] w_sum;

  // The caller only decrements a non-zero count, so the wide sum never underflows.
  always_comb begin
    w_sum  = {1'b0, i_cur} + WX'(i_add) - WX'(i_dec);
    o_sat  = w_sum[W];
    o_next = o_sat ? {W{1'b1}} : w_sum[W-1:0];
  end

endmodule

// File: rtl/event_pulse_feeder.sv
// Turns batches of events into single-cycle pulses toward a clock-domain crossing,
// honouring downstream back-pressure and an optional idle gap between pulses.
module event_pulse_feeder
  import event_pulse_feeder_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                clkin,
  input  logic                clr_in,
  input  logic                ev_valid,
  input  logic [EV_NUM_W-1:0] ev_num,
  input  logic                flush,
  input  logic                full,
  output logic                sigout,
  output logic [CNT_W-1:0]    pending,
  output logic                ovf,
  output logic                busy
);

  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  feederState_t        r_state;
  feederState_t        w_stateNext;
  logic [CNT_W-1:0]    r_pending;
  logic [CNT_W-1:0]    w_pendNext;
  logic [GCW-1:0]      r_gapCnt;
  logic [GCW-1:0]      w_gapCntNext;
  logic                r_sigout;
  logic                r_ovf;
  logic                w_pulse;
  logic                w_sat;
  logic                w_pendNz;
  logic [EV_NUM_W-1:0] w_add;

  assign w_pendNz = (r_pending != '0);
  assign w_add    = ev_valid ? ev_num : '0;

  sat_counter #(
    .W  (CNT_W),
    .AW (EV_NUM_W)
  ) u_satCounter (
    .i_cur  (r_pending),
    .i_add  (w_add),
    .i_dec  (w_pulse),
    .o_next (w_pendNext),
    .o_sat  (w_sat)
  );

  // A pulse is only ever issued from SEND with work pending and no back-pressure.
  always_comb begin
    w_stateNext  = r_state;
    w_gapCntNext = r_gapCnt;
    w_pulse      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pendNz) w_stateNext = SEND;
      end
      SEND: begin
        if (!w_pendNz) begin
          w_stateNext = IDLE;
        end else if (full) begin
          w_stateNext = STALL;
        end else begin
          w_pulse = 1'b1;
          if (GAP > 0) begin
            w_stateNext  = GAPW;
            w_gapCntNext = '0;
          end
        end
      end
      GAPW: begin
        if (int'(r_gapCnt) >= GAP - 1) begin
          w_gapCntNext = '0;
          w_stateNext  = w_pendNz ? SEND : IDLE;
        end else begin
          w_gapCntNext = r_gapCnt + 1'b1;
        end
      end
      STALL: begin
        if (!full) w_stateNext = SEND;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Flush drops everything including a same-cycle batch, but leaves the sticky overflow alone.
  always_ff @(posedge clkin) begin
    if (clr_in) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_gapCnt  <= '0;
      r_sigout  <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_gapCnt  <= '0;
      r_sigout  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pending <= w_pendNext;
      r_gapCnt  <= w_gapCntNext;
      r_sigout  <= w_pulse;
      r_ovf     <= r_ovf | w_sat;
    end
  end

  assign sigout  = r_sigout;
  assign pending = r_pending;
  assign ovf     = r_ovf;
  assign busy    = w_pendNz || (r_state != IDLE);

endmodule

// File: tb/tb_event_pulse_feeder.sv
// Randomized and directed bench for event_pulse_feeder; drives a GAP=0 and a GAP=2
// instance from the same inputs and compares both against a behavioural model.
module tb_event_pulse_feeder;

  localparam int GAP1 = 2;

  logic       clkin = 1'b0;
  logic       clrIn;
  logic       evValid;
  logic [3:0] evNum;
  logic       flushIn;
  logic       fullIn;

  logic       sig0, sig1;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;
  logic       busy0, busy1;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int lastEdge    = 0;
  int busyFall0   = -1;
  bit prevBusy0   = 1'b0;
  bit chkEn       = 1'b0;
  int pulseQ0[$];
  int pulseQ1[$];

  bit sClr, sValid, sFlush, sFull;
  int sNum;
  int mPend[2];
  int mCool[2];
  bit mWarm[2];
  bit mBlk[2];
  bit mOvf[2];
  bit mSig[2];

  always #5 clkin = ~clkin;

  event_pulse_feeder #(.CNT_W(8), .GAP(0)) u_dut0 (
    .clkin (clkin), .clr_in (clrIn), .ev_valid (evValid), .ev_num (evNum),
    .flush (flushIn), .full (fullIn), .sigout (sig0), .pending (pend0),
    .ovf (ovf0), .busy (busy0)
  );

  event_pulse_feeder #(.CNT_W(8), .GAP(GAP1)) u_dut1 (
    .clkin (clkin), .clr_in (clrIn), .ev_valid (evValid), .ev_num (evNum),
    .flush (flushIn), .full (fullIn), .sigout (sig1), .pending (pend1),
    .ovf (ovf1), .busy (busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int qAt(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // Behavioural model: "warm" means the feeder has noticed work, "blocked" means waiting
  // out back-pressure, "cool" counts remaining gap edges after a pulse.
  task automatic modelStep(input int d, input int gap);
    int add, sum, pls;
    pls = 0;
    if (sClr) begin
      mPend[d] = 0; mWarm[d] = 0; mBlk[d] = 0; mCool[d] = 0; mOvf[d] = 0;
    end else if (sFlush) begin
      mPend[d] = 0; mWarm[d] = 0; mBlk[d] = 0; mCool[d] = 0;
    end else begin
      if (mCool[d] > 0) begin
        mCool[d]--;
        if (mCool[d] == 0) mWarm[d] = (mPend[d] != 0);
      end else if (mBlk[d]) begin
        if (!sFull) mBlk[d] = 0;
      end else if (mWarm[d]) begin
        if (mPend[d] == 0) mWarm[d] = 0;
        else if (sFull) mBlk[d] = 1;
        else begin
          pls = 1;
          mCool[d] = gap;
        end
      end else begin
        mWarm[d] = (mPend[d] != 0);
      end
      add = sValid ? sNum : 0;
      sum = mPend[d] + add - pls;
      if (sum > 255) begin
        sum = 255;
        mOvf[d] = 1;
      end
      mPend[d] = sum;
    end
    mSig[d] = (pls != 0);
  endtask

  always begin
    @(posedge clkin);
    cyc++;
    sClr = clrIn; sValid = evValid; sNum = int'(evNum); sFlush = flushIn; sFull = fullIn;
    modelStep(0, 0);
    modelStep(1, GAP1);
    if (sClr) chkEn = 1'b1;
    @(negedge clkin);
    if (chkEn) begin
      checkOutput("sigout0", sig0, mSig[0]);
      checkOutput("pending0", pend0, mPend[0]);
      checkOutput("ovf0", ovf0, mOvf[0]);
      checkOutput("busy0", busy0, (mPend[0] != 0) || mWarm[0] || mBlk[0] || (mCool[0] > 0));
      checkOutput("sigout1", sig1, mSig[1]);
      checkOutput("pending1", pend1, mPend[1]);
      checkOutput("ovf1", ovf1, mOvf[1]);
      checkOutput("busy1", busy1, (mPend[1] != 0) || mWarm[1] || mBlk[1] || (mCool[1] > 0));
    end
    if (sig0 === 1'b1) pulseQ0.push_back(cyc);
    if (sig1 === 1'b1) pulseQ1.push_back(cyc);
    if (prevBusy0 && busy0 === 1'b0) busyFall0 = cyc;
    prevBusy0 = (busy0 === 1'b1);
  end

  task automatic applyStimulus(input bit v, input int n, input bit f, input bit fl, input bit c);
    @(posedge clkin);
    #1;
    evValid = v;
    evNum   = 4'(n);
    fullIn  = f;
    flushIn = fl;
    clrIn   = c;
    lastEdge = cyc + 1;
  endtask

  task automatic idle(input int k);
    repeat (k) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic clearLogs();
    pulseQ0.delete();
    pulseQ1.delete();
    busyFall0 = -1;
  endtask

  initial begin
    int e, f, fullHold;
    evValid = 0; evNum = 0; fullIn = 0; flushIn = 0; clrIn = 1;
    doReset();

    // Five-event batch: five back-to-back pulses two edges after the strobe.
    clearLogs();
    applyStimulus(1, 5, 0, 0, 0);
    e = lastEdge;
    idle(30);
    checkOutput("burst5_count", pulseQ0.size(), 5);
    checkOutput("burst5_first", qAt(pulseQ0, 0), e + 2);
    checkOutput("burst5_last", qAt(pulseQ0, 4), e + 6);
    checkOutput("burst5_busyfall", busyFall0, e + 7);
    checkOutput("burst5_gap_count", pulseQ1.size(), 5);

    // Three events with a two-cycle gap: pulses three edges apart.
    clearLogs();
    applyStimulus(1, 3, 0, 0, 0);
    e = lastEdge;
    idle(30);
    checkOutput("gap_count", pulseQ1.size(), 3);
    checkOutput("gap_p0", qAt(pulseQ1, 0), e + 2);
    checkOutput("gap_p1", qAt(pulseQ1, 1), e + 5);
    checkOutput("gap_p2", qAt(pulseQ1, 2), e + 8);
    checkOutput("nogap_count3", pulseQ0.size(), 3);

    // Back-pressure for ten edges right after the first pulse.
    clearLogs();
    applyStimulus(1, 4, 0, 0, 0);
    e = lastEdge;
    idle(2);
    repeat (10) applyStimulus(0, 0, 1, 0, 0);
    idle(30);
    checkOutput("stall_count", pulseQ0.size(), 4);
    checkOutput("stall_first", qAt(pulseQ0, 0), e + 2);
    checkOutput("stall_resume", qAt(pulseQ0, 1), e + 14);
    checkOutput("stall_last", qAt(pulseQ0, 3), e + 16);
    checkOutput("stall_gap_count", pulseQ1.size(), 4);

    // Fill to 250 under back-pressure, then one more batch of 15 saturates.
    doReset();
    clearLogs();
    repeat (16) applyStimulus(1, 15, 1, 0, 0);
    applyStimulus(1, 10, 1, 0, 0);
    applyStimulus(1, 15, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clkin);
    checkOutput("sat_pending", pend0, 255);
    checkOutput("sat_ovf", ovf0, 1);
    idle(800);
    checkOutput("sat_count0", pulseQ0.size(), 255);
    checkOutput("sat_count1", pulseQ1.size(), 255);
    checkOutput("sat_ovf_sticky0", ovf0, 1);
    checkOutput("sat_ovf_sticky1", ovf1, 1);
    checkOutput("sat_drained", pend0, 0);

    // Flush mid-burst together with a fresh batch of seven.
    doReset();
    clearLogs();
    applyStimulus(1, 10, 0, 0, 0);
    e = lastEdge;
    idle(4);
    applyStimulus(1, 7, 0, 1, 0);
    f = lastEdge;
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clkin);
    checkOutput("flush_pending0", pend0, 0);
    checkOutput("flush_sigout0", sig0, 0);
    checkOutput("flush_busy0", busy0, 0);
    checkOutput("flush_pending1", pend1, 0);
    idle(20);
    checkOutput("flush_count0", pulseQ0.size(), f - e - 2);
    checkOutput("flush_count1", pulseQ1.size(), 1);

    // Random traffic with bursty back-pressure, occasional flushes and resets.
    doReset();
    fullHold = 0;
    repeat (3000) begin
      if (fullHold > 0) fullHold--;
      else if ($urandom_range(0, 9) == 0) fullHold = int'($urandom_range(1, 6));
      applyStimulus($urandom_range(0, 4) == 0, int'($urandom_range(0, 15)), fullHold > 0,
                    $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
    end
    idle(60);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
